// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared types, note limit table and sine helper for the tone engine
package sfx_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_PLAY
    } sfx_state_e;

    typedef enum logic [1:0] {
        NOTE_C,
        NOTE_D,
        NOTE_E,
        NOTE_G
    } sfx_note_e;

    localparam int LIMIT_W = 12;

    // Divider limit per note, indexed by sfx_note_e.
    localparam logic [LIMIT_W-1:0] NOTE_LIMIT [4] = '{12'hBAA, 12'hA64, 12'h941, 12'h7C9};

    // First quarter of a sine wave in Q8 (256 = full scale).
    localparam int unsigned SINE_Q8 [9] = '{0, 50, 98, 142, 181, 213, 237, 251, 256};

    // Positive half swings up to 2^w-1, negative half down to 0 around midscale 2^(w-1).
    function automatic int unsigned sine_sample(input logic [4:0] ph, input int unsigned tone_w);
        int unsigned mid;
        int unsigned mag;
        logic [3:0]  q;
        mid = 32'd1 << (tone_w - 32'd1);
        q   = (ph[3:0] > 4'd8) ? (4'd0 - ph[3:0]) : ph[3:0];
        if (!ph[4]) begin
            mag         = (SINE_Q8[q] * (mid - 32'd1) + 32'd128) >> 8;
            sine_sample = mid + mag;
        end else begin
            mag         = (SINE_Q8[q] * mid + 32'd128) >> 8;
            sine_sample = mid - mag;
        end
    endfunction

endpackage

// File: rtl/sfx_wave_rom.sv
// rtl/sfx_wave_rom.sv - phase to sample lookup with registered output; SFX_SINE_EN selects sine, else square
module sfx_wave_rom
    import sfx_pkg::*;
#(
    parameter int TONE_W = 4
) (
    input  logic              clk50mhz,
    input  logic              reset_n,
    input  logic              en,
    input  logic [4:0]        phase,
    output logic [TONE_W-1:0] sample
);

    logic [TONE_W-1:0] wave;
    logic [TONE_W-1:0] sample_d;
    logic [TONE_W-1:0] sample_q;

`ifdef SFX_SINE_EN
    always_comb begin
        wave = TONE_W'(sine_sample(phase, TONE_W));
    end
`else
    always_comb begin
        wave = phase[4] ? '0 : '1;
    end
`endif

    always_comb begin
        sample_d = en ? wave : '0;
    end

    always_ff @(posedge clk50mhz or negedge reset_n) begin
        if (!reset_n) begin
            sample_q <= '0;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign sample = sample_q;

endmodule

// File: rtl/sfx_tone_engine.sv
// rtl/sfx_tone_engine.sv - prioritised multi-channel note player; waveform selected by SFX_SINE_EN
module sfx_tone_engine
    import sfx_pkg::*;
#(
    parameter int               CHANNELS  = 2,
    parameter int               TONE_W    = 4,
    parameter int               DUR_W     = 24,
    parameter logic [DUR_W-1:0] DURATION  = 24'h4C4B40,
    parameter int               DIV_SHIFT = 0,
    localparam int              CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk50mhz,
    input  logic                  reset_n,
    input  logic [CHANNELS-1:0]   trig,
    input  logic [2*CHANNELS-1:0] note,
    output logic [TONE_W-1:0]     tone,
    output logic                  busy,
    output logic [CH_W-1:0]       active_ch
);

    localparam logic [DUR_W-1:0] DUR_LAST = DURATION - DUR_W'(1);

    sfx_state_e         state_d, state_q;
    sfx_note_e          cur_note_d, cur_note_q;
    logic [CH_W-1:0]    active_ch_d, active_ch_q;
    logic [LIMIT_W-1:0] div_cnt_d, div_cnt_q;
    logic [4:0]         phase_d, phase_q;
    logic [DUR_W-1:0]   dur_cnt_d, dur_cnt_q;

    int                 win_int;
    logic [CH_W-1:0]    win_ch;
    logic [1:0]         win_note;
    logic               accept;
    logic [LIMIT_W-1:0] limit_raw;
    logic [LIMIT_W-1:0] div_last;
    logic               play_next;

    always_comb begin
        win_int = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (trig[k]) begin
                win_int = k;
            end
        end
        win_ch   = CH_W'(win_int);
        win_note = note[2*win_int +: 2];
        // Equal-priority retrigger is accepted so a channel can restart its own note.
        accept   = (|trig) && ((state_q == ST_IDLE) || (win_ch >= active_ch_q));

        limit_raw = NOTE_LIMIT[cur_note_q] >> DIV_SHIFT;
        div_last  = (limit_raw == '0) ? '0 : (limit_raw - LIMIT_W'(1));
    end

    always_comb begin
        state_d     = state_q;
        cur_note_d  = cur_note_q;
        active_ch_d = active_ch_q;
        div_cnt_d   = div_cnt_q;
        phase_d     = phase_q;
        dur_cnt_d   = dur_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (!accept && (dur_cnt_q == DUR_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            cur_note_d  = sfx_note_e'(win_note);
            active_ch_d = win_ch;
            div_cnt_d   = '0;
            phase_d     = '0;
            dur_cnt_d   = '0;
        end else if ((state_q == ST_PLAY) && (state_d == ST_PLAY)) begin
            dur_cnt_d = dur_cnt_q + DUR_W'(1);
            if (div_cnt_q >= div_last) begin
                div_cnt_d = '0;
                phase_d   = phase_q + 5'd1;
            end else begin
                div_cnt_d = div_cnt_q + LIMIT_W'(1);
            end
        end

        // The sample register only follows the phase while the note continues into the next cycle.
        play_next = (state_q == ST_PLAY) && (state_d == ST_PLAY);
    end

    always_ff @(posedge clk50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cur_note_q  <= NOTE_C;
            active_ch_q <= '0;
            div_cnt_q   <= '0;
            phase_q     <= '0;
            dur_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_note_q  <= cur_note_d;
            active_ch_q <= active_ch_d;
            div_cnt_q   <= div_cnt_d;
            phase_q     <= phase_d;
            dur_cnt_q   <= dur_cnt_d;
        end
    end

    sfx_wave_rom #(
        .TONE_W (TONE_W)
    ) u_wave_rom (
        .clk50mhz (clk50mhz),
        .reset_n  (reset_n),
        .en       (play_next),
        .phase    (phase_q),
        .sample   (tone)
    );

    assign busy      = (state_q == ST_PLAY);
    assign active_ch = active_ch_q;

endmodule

// File: tb/tb_sfx_tone_engine.sv
// tb/tb_sfx_tone_engine.sv - self-checking bench for sfx_tone_engine; honours SFX_SINE_EN
module tb_sfx_tone_engine;

    localparam int TW   = 4;
    localparam int DUR  = 2000;
    localparam int SHFT = 4;
    localparam int PK   = (1 << TW) - 1;

    logic          clk50mhz = 1'b0;
    logic          reset_n;
    logic [1:0]    trig;
    logic [3:0]    note;
    logic [TW-1:0] tone;
    logic          busy;
    logic [0:0]    active_ch;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    int lim_tab [4] = '{'hBAA, 'hA64, 'h941, 'h7C9};

    bit m_busy;
    int m_ch, m_note, m_elapsed, m_tone;

    sfx_tone_engine #(
        .CHANNELS  (2),
        .TONE_W    (TW),
        .DUR_W     (24),
        .DURATION  (24'd2000),
        .DIV_SHIFT (SHFT)
    ) dut (
        .clk50mhz  (clk50mhz),
        .reset_n   (reset_n),
        .trig      (trig),
        .note      (note),
        .tone      (tone),
        .busy      (busy),
        .active_ch (active_ch)
    );

    always #5 clk50mhz = ~clk50mhz;

    function automatic int note_limit(input int n);
        int l;
        l = lim_tab[n] >> SHFT;
        return (l == 0) ? 1 : l;
    endfunction

    function automatic int wave_of(input int ph);
`ifdef SFX_SINE_EN
        real s;
        s = $sin(2.0 * 3.14159265358979 * ph / 32.0);
        if (s >= 0.0) return (PK + 1) / 2 + $rtoi(((PK + 1) / 2 - 1) * s + 0.5);
        return (PK + 1) / 2 - $rtoi(((PK + 1) / 2) * (-s) + 0.5);
`else
        return (ph < 16) ? PK : 0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: phase is simply elapsed note time divided by the note's limit.
    always @(posedge clk50mhz or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0; m_ch = 0; m_note = 0; m_elapsed = 0; m_tone = 0;
        end else begin
            bit prev_busy, nb, acc;
            int prev_phase, win;
            prev_busy  = m_busy;
            prev_phase = (m_elapsed / note_limit(m_note)) % 32;
            win = trig[1] ? 1 : 0;
            acc = (trig != 2'b00) && (!m_busy || win >= m_ch);
            nb  = m_busy;
            if (acc) begin
                nb = 1'b1; m_ch = win; m_note = int'(note[2*win +: 2]); m_elapsed = 0;
            end else if (m_busy && m_elapsed == DUR - 1) begin
                nb = 1'b0;
            end else if (m_busy) begin
                m_elapsed++;
            end
            m_tone = (prev_busy && nb) ? wave_of(prev_phase) : 0;
            m_busy = nb;
        end
    end

    always @(negedge clk50mhz) begin
        if (cmp_en) begin
            chk("busy", int'(busy), int'(m_busy));
            chk("active_ch", int'(active_ch), m_ch);
`ifdef SFX_SINE_EN
            checks++;
            if ((int'(tone) - m_tone > 1) || (m_tone - int'(tone) > 1)) begin
                errors++;
                $display("FAIL tone: actual=%0d expected=%0d at %0t", tone, m_tone, $time);
            end
`else
            chk("tone", int'(tone), m_tone);
`endif
        end
    end

    task automatic pulse(input logic [1:0] t, input logic [3:0] n);
        trig = t;
        note = n;
        @(negedge clk50mhz);
        trig = 2'b00;
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk50mhz);
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL busy_timeout: actual=%0d expected<5000", n);
        end
    endtask

    initial begin
        int n, hi, first, peak;
        reset_n = 1'b0;
        trig    = 2'b00;
        note    = 4'b0000;
        repeat (3) @(negedge clk50mhz);
        chk("reset_busy", int'(busy), 0);
        chk("reset_tone", int'(tone), 0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(negedge clk50mhz);
        chk("idle_active_ch", int'(active_ch), 0);
        chk("idle_tone", int'(tone), 0);

        // Single note on channel 0 runs for exactly DURATION cycles.
        pulse(2'b01, 4'b0000);
        chk("c_busy_rise", int'(busy), 1);
        chk("c_active_ch", int'(active_ch), 0);
        wait_fall(n);
        chk("c_note_len", n, DUR);
        chk("c_tone_after", int'(tone), 0);

        // Simultaneous triggers: channel 1 (note G, limit 124) wins.
        pulse(2'b11, 4'b1100);
        chk("g_active_ch", int'(active_ch), 1);
        hi = 0; first = -1; peak = -1; n = 1;
        while (busy && n < 5000) begin
            if (int'(tone) == PK) hi++;
            if (n == 2) first = int'(tone);
            if (n == 994) peak = int'(tone);
            n++;
            @(negedge clk50mhz);
        end
`ifdef SFX_SINE_EN
        chk("sine_first", first, 8);
        chk("sine_peak", peak, 15);
`else
        chk("sq_first", first, 15);
        chk("sq_high_cycles", hi, 1984);
`endif
        chk("g_note_len", n - 1, DUR);

        // Lower-priority trigger mid-note is ignored and the note keeps its timing.
        pulse(2'b10, 4'b1100);
        repeat (300) @(negedge clk50mhz);
        pulse(2'b01, 4'b0000);
        chk("ignored_active_ch", int'(active_ch), 1);
        wait_fall(n);
        chk("ignored_remaining", n, 1699);

        // Higher-priority trigger preempts channel 0.
        pulse(2'b01, 4'b0000);
        repeat (100) @(negedge clk50mhz);
        pulse(2'b10, 4'b1100);
        chk("preempt_active_ch", int'(active_ch), 1);
        wait_fall(n);
        chk("preempt_len", n, DUR);

        // Trigger landing in the expiry cycle restarts without a gap.
        pulse(2'b10, 4'b1100);
        repeat (1999) @(negedge clk50mhz);
        chk("expiry_busy_before", int'(busy), 1);
        pulse(2'b10, 4'b1100);
        chk("expiry_busy_after", int'(busy), 1);
        wait_fall(n);
        chk("expiry_restart_len", n, DUR);

        // Asynchronous reset mid-note clears outputs before the next edge.
        pulse(2'b01, 4'b0000);
        repeat (50) @(negedge clk50mhz);
        @(posedge clk50mhz);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_tone", int'(tone), 0);
        @(negedge clk50mhz);
        reset_n = 1'b1;
        repeat (3) @(negedge clk50mhz);
        chk("post_reset_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
